// File: rtl/t0_arb_pkg.sv
// rtl/t0_arb_pkg.sv - shared types and helpers for the T0 bus arbiter
package t0_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} arb_state_t;

  // Index width for N requesters; kept at least one bit so a 2-requester id is legal.
  function automatic int t0_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // True when a is the successor of prev modulo 2^aw.
  function automatic logic t0_is_seq(input logic [31:0] prev, input logic [31:0] a,
                                     input int aw);
    logic [31:0] m;
    m = (aw >= 32) ? 32'hffff_ffff : ((32'd1 << aw) - 32'd1);
    return ((prev + 32'd1) & m) == (a & m);
  endfunction

endpackage

// File: rtl/t0_rr_picker.sv
// rtl/t0_rr_picker.sv - combinational round-robin winner search
module t0_rr_picker
  import t0_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int ID_W = t0_id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  input  logic [N_REQ-1:0] excl,
  output logic [N_REQ-1:0] win_oh,
  output logic [ID_W-1:0]  win_idx,
  output logic             win_vld
);

  logic [N_REQ-1:0] cand;

  assign cand = req & ~excl;

  always_comb begin
    int idx;
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!win_vld && cand[idx]) begin
        win_vld      = 1'b1;
        win_oh[idx]  = 1'b1;
        win_idx      = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/t0_bus_arbiter.sv
// rtl/t0_bus_arbiter.sv - burst-aware round-robin arbiter feeding a T0-encoded bus
module t0_bus_arbiter
  import t0_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int AW        = 8,
  parameter int MAX_BURST = 8,
  localparam int ID_W     = t0_id_w(N_REQ)
) (
  input  logic              ck,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ*AW-1:0] addr,
  output logic [N_REQ-1:0]  gnt,
  output logic [AW-1:0]     bus_b,
  output logic              bus_inc,
  output logic [ID_W-1:0]   bus_id,
  output logic              bus_vld
);

  arb_state_t       state, state_nx;
  logic [ID_W-1:0]  owner, owner_nx;
  logic [ID_W-1:0]  rr_ptr, rr_ptr_nx;
  logic [7:0]       beat_cnt, beat_cnt_nx;
  logic [AW-1:0]    prev_addr;
  logic             have_prev;

  logic [N_REQ-1:0] owner_oh, excl, pick_oh;
  logic [ID_W-1:0]  pick_idx, sel_idx;
  logic             pick_vld, cont, beat;
  logic [AW-1:0]    owner_addr, sel_addr;

  always_comb begin
    owner_oh = '0;
    owner_oh[owner] = 1'b1;
  end

  assign owner_addr = addr[int'(owner)*AW +: AW];
  assign cont = (state == BURST) && req[owner] && (int'(beat_cnt) < MAX_BURST) &&
                t0_is_seq(32'(prev_addr), 32'(owner_addr), AW);

  // A requester that used its full burst yields, unless nobody else is waiting.
  assign excl = ((state == BURST) && (int'(beat_cnt) >= MAX_BURST) &&
                 ((req & ~owner_oh) != '0)) ? owner_oh : '0;

  t0_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .excl    (excl),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_vld (pick_vld)
  );

  assign beat     = !rst && (cont || pick_vld);
  assign sel_idx  = cont ? owner : pick_idx;
  assign sel_addr = addr[int'(sel_idx)*AW +: AW];
  assign gnt      = rst ? '0 : (cont ? owner_oh : pick_oh);

  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    rr_ptr_nx   = rr_ptr;
    beat_cnt_nx = beat_cnt;
    if (cont) begin
      beat_cnt_nx = beat_cnt + 8'd1;
    end else if (pick_vld) begin
      state_nx    = BURST;
      owner_nx    = pick_idx;
      beat_cnt_nx = 8'd1;
      rr_ptr_nx   = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + ID_W'(1);
    end else begin
      state_nx = IDLE;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      prev_addr <= '0;
      have_prev <= 1'b0;
      bus_b     <= '0;
      bus_inc   <= 1'b0;
      bus_id    <= '0;
      bus_vld   <= 1'b0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      rr_ptr   <= rr_ptr_nx;
      beat_cnt <= beat_cnt_nx;
      bus_vld  <= beat;
      bus_inc  <= 1'b0;
      if (beat) begin
        // Sequential beats freeze the bus word regardless of which requester sent them.
        if (have_prev && t0_is_seq(32'(prev_addr), 32'(sel_addr), AW)) begin
          bus_inc <= 1'b1;
        end else begin
          bus_b <= sel_addr;
        end
        bus_id    <= sel_idx;
        prev_addr <= sel_addr;
        have_prev <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_t0_bus_arbiter.sv
// tb/tb_t0_bus_arbiter.sv - directed self-checking bench for t0_bus_arbiter
module tb_t0_bus_arbiter;

  logic        ck = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] addr;
  logic [3:0]  gnt;
  logic [7:0]  bus_b;
  logic        bus_inc;
  logic [1:0]  bus_id;
  logic        bus_vld;

  int n_pass = 0;
  int n_total = 0;

  t0_bus_arbiter #(.N_REQ(4), .AW(8), .MAX_BURST(4)) dut (
    .ck      (ck),
    .rst     (rst),
    .req     (req),
    .addr    (addr),
    .gnt     (gnt),
    .bus_b   (bus_b),
    .bus_inc (bus_inc),
    .bus_id  (bus_id),
    .bus_vld (bus_vld)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge ck);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [7:0] a);
    addr[i*8 +: 8] = a;
  endtask

  task automatic chk_bus(input string tag, input logic [7:0] b, input logic inc,
                         input logic [1:0] id, input logic vld);
    chk({tag, ".b"}, 32'(bus_b), 32'(b));
    chk({tag, ".inc"}, 32'(bus_inc), 32'(inc));
    chk({tag, ".id"}, 32'(bus_id), 32'(id));
    chk({tag, ".vld"}, 32'(bus_vld), 32'(vld));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    addr = '0;
    do_reset();
    #1;
    chk("reset.gnt", 32'(gnt), 32'h0);
    chk_bus("reset", 8'h00, 1'b0, 2'd0, 1'b0);

    // Single requester sequential burst.
    req = 4'b0100;
    set_addr(2, 8'h10); #1; chk("seq.gnt0", 32'(gnt), 32'h4); cyc();
    chk_bus("seq.beat0", 8'h10, 1'b0, 2'd2, 1'b1);
    set_addr(2, 8'h11); #1; chk("seq.gnt1", 32'(gnt), 32'h4); cyc();
    chk_bus("seq.beat1", 8'h10, 1'b1, 2'd2, 1'b1);
    set_addr(2, 8'h12); #1; chk("seq.gnt2", 32'(gnt), 32'h4); cyc();
    chk_bus("seq.beat2", 8'h10, 1'b1, 2'd2, 1'b1);

    // Two non-sequential requesters alternate.
    do_reset();
    req = 4'b0011;
    set_addr(0, 8'h40);
    set_addr(1, 8'h80);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("alt.gnt%0d", k), 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
      cyc();
      chk($sformatf("alt.inc%0d", k), 32'(bus_inc), 32'h0);
      chk($sformatf("alt.id%0d", k), 32'(bus_id), 32'(k % 2));
    end

    // Burst cap: requester 0 streams, requester 3 waits.
    do_reset();
    req = 4'b1001;
    set_addr(3, 8'h90);
    for (int k = 0; k < 4; k++) begin
      set_addr(0, 8'(k));
      #1;
      chk($sformatf("cap.gnt%0d", k), 32'(gnt), 32'h1);
      cyc();
    end
    set_addr(0, 8'h04);
    #1; chk("cap.gnt4", 32'(gnt), 32'h8); cyc();
    chk_bus("cap.beat4", 8'h90, 1'b0, 2'd3, 1'b1);
    #1; chk("cap.gnt5", 32'(gnt), 32'h1); cyc();
    chk_bus("cap.beat5", 8'h04, 1'b0, 2'd0, 1'b1);

    // Address wrap counts as sequential.
    do_reset();
    req = 4'b0010;
    set_addr(1, 8'hff); cyc();
    chk_bus("wrap.beat0", 8'hff, 1'b0, 2'd1, 1'b1);
    set_addr(1, 8'h00); cyc();
    chk_bus("wrap.beat1", 8'hff, 1'b1, 2'd1, 1'b1);

    // Idle gap keeps the bus word and sequence history.
    do_reset();
    req = 4'b0010;
    set_addr(1, 8'h20); cyc();
    chk_bus("gap.beat0", 8'h20, 1'b0, 2'd1, 1'b1);
    req = 4'b0000;
    cyc();
    chk("gap.vld0", 32'(bus_vld), 32'h0);
    chk("gap.b0", 32'(bus_b), 32'h20);
    chk("gap.inc0", 32'(bus_inc), 32'h0);
    cyc();
    chk("gap.vld1", 32'(bus_vld), 32'h0);
    chk("gap.b1", 32'(bus_b), 32'h20);
    req = 4'b0010;
    set_addr(1, 8'h21);
    #1; chk("gap.gnt", 32'(gnt), 32'h2); cyc();
    chk_bus("gap.beat1", 8'h20, 1'b1, 2'd1, 1'b1);

    // Reset in the middle of the burst discards the sequence history.
    set_addr(1, 8'h22);
    rst = 1'b1;
    #1; chk("rst.gnt", 32'(gnt), 32'h0);
    cyc();
    chk_bus("rst.out", 8'h00, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    set_addr(1, 8'h21);
    #1; chk("rst.gnt_after", 32'(gnt), 32'h2);
    cyc();
    chk_bus("rst.beat", 8'h21, 1'b0, 2'd1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
